// File: rtl/iccm_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module : iccm_boot_pkg
// Brief  : Shared types and constants for the ICCM boot arbiter
// Rev    : 1.0  initial release
// ============================================================================
package iccm_boot_pkg;

  // Arbiter phases: BOOT samples the strap, LOAD programs over UART, RUN serves fetch
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } boot_st_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  // Assembled word that ends programming; it is never written to the ICCM
  localparam logic [WORD_W-1:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage
`default_nettype wire

// File: rtl/iccm_word_packer.sv
`default_nettype none
// ============================================================================
// Module : iccm_word_packer
// Brief  : Assembles little-endian UART bytes into ICCM words
// Rev    : 1.0  initial release
// ============================================================================
module iccm_word_packer
  import iccm_boot_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              en_i,
  input  logic              dv_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;

  // Drop each accepted byte into its lane; the word is complete on the last lane
  always_comb begin
    sh_d       = sh_q;
    byte_cnt_d = byte_cnt_q;
    word_vld_o = 1'b0;
    if (en_i && dv_i) begin
      sh_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
      byte_cnt_d = byte_cnt_q + 2'd1;
      word_vld_o = (byte_cnt_q == LAST_BYTE);
    end
  end

  // Next-state value already carries the final byte, so the word is usable in the same cycle
  assign word_o = sh_d;

  // Shift register and lane counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_q       <= '0;
      byte_cnt_q <= '0;
    end else begin
      sh_q       <= sh_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iccm_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module : iccm_boot_arbiter
// Brief  : Shares the ICCM port between the UART boot loader and instruction
//          fetch; sequences boot and holds the core in reset while loading
// Rev    : 1.0  initial release
// ============================================================================
module iccm_boot_arbiter
  import iccm_boot_pkg::*;
#(
  parameter int              AW       = 12,
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   END_WORD = END_WORD_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_en_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              fetch_req_i,
  input  logic [AW-1:0]     fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic [DW-1:0]     fetch_rdata_o,
  output logic              fetch_rvalid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [DW/8-1:0]   mem_wmask_o,
  input  logic [DW-1:0]     mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              core_rst_o,
  output logic              prog_done_o,
  output logic              prog_err_o
);

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  boot_st_e          st_q, st_d;
  logic [AW-1:0]     word_addr_q, word_addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              wr_pend_q, wr_pend_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              load, run;
  logic [WORD_W-1:0] pk_word;
  logic              pk_vld;

  assign load = (st_q == LOAD);
  assign run  = (st_q == RUN);

  iccm_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .en_i       (load),
    .dv_i       (rx_dv_i),
    .byte_i     (rx_byte_i),
    .word_o     (pk_word),
    .word_vld_o (pk_vld)
  );

  // Boot sequencing, write scheduling and the ICCM address counter
  always_comb begin
    st_d        = st_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    wr_pend_d   = 1'b0;
    ovf_d       = ovf_q;
    done_d      = done_q;
    err_d       = err_q;
    case (st_q)
      BOOT: st_d = prog_en_i ? LOAD : RUN;
      LOAD: begin
        // Address advances after the write cycle; it parks at the top once full
        if (wr_pend_q) begin
          if (word_addr_q == ADDR_MAX) ovf_d = 1'b1;
          else                         word_addr_d = word_addr_q + 1'b1;
        end
        if (pk_vld) begin
          if (pk_word == END_WORD) begin
            done_d = 1'b1;
            st_d   = RUN;
          end else if (ovf_q) begin
            err_d = 1'b1;
          end else begin
            wdata_d   = pk_word;
            wr_pend_d = 1'b1;
          end
        end
      end
      RUN:     st_d = RUN;
      default: st_d = BOOT;
    endcase
  end

  // Port mux: loader owns the ICCM until RUN, then fetch passes straight through
  always_comb begin
    core_rst_o     = !run;
    fetch_gnt_o    = 1'b0;
    fetch_rdata_o  = '0;
    fetch_rvalid_o = 1'b0;
    mem_req_o      = wr_pend_q;
    mem_we_o       = wr_pend_q;
    mem_addr_o     = word_addr_q;
    mem_wdata_o    = wdata_q;
    mem_wmask_o    = {(DW/8){wr_pend_q}};
    if (run) begin
      mem_req_o      = fetch_req_i;
      mem_we_o       = 1'b0;
      mem_addr_o     = fetch_addr_i;
      mem_wmask_o    = '0;
      fetch_gnt_o    = fetch_req_i;
      fetch_rdata_o  = mem_rdata_i;
      fetch_rvalid_o = mem_rvalid_i;
    end
  end

  assign prog_done_o = done_q;
  assign prog_err_o  = err_q;

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q        <= BOOT;
      word_addr_q <= '0;
      wdata_q     <= '0;
      wr_pend_q   <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      wr_pend_q   <= wr_pend_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iccm_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_iccm_boot_arbiter
// Brief  : Self-checking bench for iccm_boot_arbiter (full-size and AW=2 DUTs)
// Rev    : 1.0  initial release
// ============================================================================
module tb_iccm_boot_arbiter;
  import iccm_boot_pkg::*;

  localparam int AW  = 12;
  localparam int AW2 = 2;
  localparam logic [31:0] ENDW = 32'h0000_0FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT signals
  logic          prog_en = 1'b0, rx_dv = 1'b0, fetch_req = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid, mem_req, mem_we, core_rst, prog_done, prog_err;
  logic [31:0]   fetch_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;

  // Small DUT signals
  logic           prog_en2 = 1'b0, rx_dv2 = 1'b0, fetch_req2 = 1'b0;
  logic [7:0]     rx_byte2 = '0;
  logic [AW2-1:0] fetch_addr2 = '0;
  logic           fetch_gnt2, fetch_rvalid2, mem_req2, mem_we2, core_rst2, prog_done2, prog_err2;
  logic [31:0]    fetch_rdata2, mem_wdata2;
  logic [AW2-1:0] mem_addr2;
  logic [3:0]     mem_wmask2;
  logic [31:0]    mem_rdata2 = '0;
  logic           mem_rvalid2 = 1'b0;

  iccm_boot_arbiter #(.AW(AW)) dut (
    .clock(clk), .reset(rst), .prog_en_i(prog_en), .rx_dv_i(rx_dv), .rx_byte_i(rx_byte),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rdata_o(fetch_rdata), .fetch_rvalid_o(fetch_rvalid), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .core_rst_o(core_rst),
    .prog_done_o(prog_done), .prog_err_o(prog_err)
  );

  iccm_boot_arbiter #(.AW(AW2)) dut2 (
    .clock(clk), .reset(rst), .prog_en_i(prog_en2), .rx_dv_i(rx_dv2), .rx_byte_i(rx_byte2),
    .fetch_req_i(fetch_req2), .fetch_addr_i(fetch_addr2), .fetch_gnt_o(fetch_gnt2),
    .fetch_rdata_o(fetch_rdata2), .fetch_rvalid_o(fetch_rvalid2), .mem_req_o(mem_req2),
    .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2), .mem_wmask_o(mem_wmask2),
    .mem_rdata_i(mem_rdata2), .mem_rvalid_i(mem_rvalid2), .core_rst_o(core_rst2),
    .prog_done_o(prog_done2), .prog_err_o(prog_err2)
  );

  // ICCM model for the main DUT: 1-cycle read latency, unwritten words return a tag pattern
  logic [31:0]   mem [0:4095];
  logic [4095:0] mem_vld = '0;
  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
    mem_rvalid <= mem_req && !mem_we;
    mem_rdata  <= mem_vld[mem_addr] ? mem[mem_addr] : {20'hA5A5A, mem_addr};
  end

  // Write monitors: every write cycle is logged so that pulse count and order can be checked
  int unsigned wa_q[$];
  logic [31:0] wd_q[$];
  int unsigned wa2_q[$];
  logic [31:0] wd2_q[$];
  int          bad_mask = 0;
  always @(negedge clk) begin
    if (mem_req && mem_we) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(mem_wdata);
      if (mem_wmask !== 4'hF) bad_mask++;
    end
    if (mem_req2 && mem_we2) begin
      wa2_q.push_back(int'(mem_addr2));
      wd2_q.push_back(mem_wdata2);
      if (mem_wmask2 !== 4'hF) bad_mask++;
    end
  end

  int errors = 0;
  int checks = 0;
  int load_viol = 0;
  bit watch_load = 1'b0;

  // Reference model state: expected ICCM contents and the words of the current session
  logic [31:0] exp_mem [int unsigned];
  logic [31:0] sess_w[$];

  function automatic logic [31:0] exp_val(input int unsigned a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return {20'hA5A5A, a[11:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    while (w == ENDW) w = $urandom;
    return w;
  endfunction

  task automatic do_reset(input logic pe, input logic pe2);
    rst = 1'b1; prog_en = pe; prog_en2 = pe2;
    rx_dv = 1'b0; rx_dv2 = 1'b0; fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sess_w.delete();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    if (watch_load && (fetch_gnt !== 1'b0 || (mem_req && !mem_we))) load_viol++;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input int gap);
    if (which == 0) begin rx_dv = 1'b1; rx_byte = b; end
    else begin rx_dv2 = 1'b1; rx_byte2 = b; end
    idle_cycle();
    rx_dv = 1'b0; rx_dv2 = 1'b0;
    repeat (gap) idle_cycle();
  endtask

  // maxgap < 0 means no gaps at all (bytes on consecutive cycles)
  task automatic send_word(input int which, input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(which, w[8*i +: 8], (maxgap < 0) ? 0 : int'($urandom_range(0, maxgap)));
    if (w != ENDW) sess_w.push_back(w);
  endtask

  // Compare logged writes since 'base' against the model: non-END word k lands at k if k < depth
  task automatic check_writes(input int which, input int base, input int depth, input string tag);
    int nexp, nact;
    nexp = (sess_w.size() < depth) ? sess_w.size() : depth;
    nact = ((which == 0) ? wa_q.size() : wa2_q.size()) - base;
    checks++;
    if (nact != nexp) begin
      errors++;
      $display("FAIL %s write_count got=%0d expected=%0d", tag, nact, nexp);
    end else begin
      for (int k = 0; k < nexp; k++) begin
        int unsigned a;
        logic [31:0] d;
        a = (which == 0) ? wa_q[base+k] : wa2_q[base+k];
        d = (which == 0) ? wd_q[base+k] : wd2_q[base+k];
        checks++;
        if (a != k || d !== sess_w[k]) begin
          errors++;
          $display("FAIL %s write[%0d] got=%0h@%0d expected=%0h@%0d", tag, k, d, a, sess_w[k], k);
        end
        if (which == 0) exp_mem[k] = sess_w[k];
      end
    end
  endtask

  task automatic fetch_reads(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = AW'($urandom_range(0, 9));
      fetch_req = 1'b1; fetch_addr = a;
      #1;
      checks++;
      if (mem_addr !== a || fetch_gnt !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wmask !== 4'h0) begin
        errors++;
        $display("FAIL fetch_pass addr=%0h gnt=%b req=%b we=%b mask=%h expected addr=%0h gnt=1 req=1 we=0 mask=0",
                 mem_addr, fetch_gnt, mem_req, mem_we, mem_wmask, a);
      end
      @(negedge clk);
      checks++;
      if (fetch_rvalid !== 1'b1 || fetch_rdata !== exp_val(int'(a))) begin
        errors++;
        $display("FAIL fetch_read addr=%0h rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                 a, fetch_rvalid, fetch_rdata, exp_val(int'(a)));
      end
    end
    fetch_req = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle rvalid=%b expected 0", fetch_rvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; prog_en = 1'b0; fetch_req = 1'b1; fetch_addr = 12'h005;
    repeat (3) @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || mem_wmask !== 4'h0 || fetch_gnt !== 1'b0 || fetch_rvalid !== 1'b0 ||
        fetch_rdata !== '0 || prog_done !== 1'b0 || prog_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values core_rst=%b req=%b we=%b addr=%0h wdata=%h mask=%h gnt=%b rv=%b rd=%h done=%b err=%b expected 1 and all others 0",
               core_rst, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, fetch_gnt, fetch_rvalid,
               fetch_rdata, prog_done, prog_err);
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_run_direct();
    int cyc;
    do_reset(1'b0, 1'b0);
    cyc = 0;
    while (core_rst !== 1'b0 && cyc < 2) begin @(negedge clk); cyc++; end
    checks++;
    if (core_rst !== 1'b0 || prog_done !== 1'b0) begin
      errors++;
      $display("FAIL direct_run core_rst=%b done=%b expected core_rst=0 done=0 within 2 cycles", core_rst, prog_done);
    end
    fetch_req = 1'b1; fetch_addr = 12'h005;
    #1;
    checks++;
    if (mem_addr !== 12'h005 || fetch_gnt !== 1'b1) begin
      errors++;
      $display("FAIL direct_addr5 addr=%0h gnt=%b expected addr=5 gnt=1", mem_addr, fetch_gnt);
    end
    fetch_reads(6);
  endtask

  task automatic test_program();
    int base, nbefore;
    do_reset(1'b1, 1'b0);
    @(negedge clk);
    base = wa_q.size();
    load_viol = 0; bad_mask = 0;
    fetch_req = 1'b1; fetch_addr = AW'($urandom_range(0, 4095));
    watch_load = 1'b1;
    send_word(0, 32'h1234_5678, -1);
    send_word(0, 32'hDEAD_BEEF, -1);
    for (int i = 0; i < 5; i++) send_word(0, rand_word(), (i % 2 == 0) ? -1 : 2);
    repeat (2) idle_cycle();
    watch_load = 1'b0;
    fetch_req = 1'b0;
    checks++;
    if (load_viol != 0) begin
      errors++;
      $display("FAIL load_fetch_blocked violations=%0d expected 0", load_viol);
    end
    checks++;
    if (prog_done !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL pre_end done=%b core_rst=%b expected done=0 core_rst=1", prog_done, core_rst);
    end
    send_word(0, ENDW, -1);
    checks++;
    if (prog_done !== 1'b1 || core_rst !== 1'b0 || prog_err !== 1'b0) begin
      errors++;
      $display("FAIL end_marker done=%b core_rst=%b err=%b expected done=1 core_rst=0 err=0", prog_done, core_rst, prog_err);
    end
    check_writes(0, base, 1 << AW, "program");
    checks++;
    if (bad_mask != 0) begin
      errors++;
      $display("FAIL write_mask bad=%0d expected 0", bad_mask);
    end
    nbefore = wa_q.size();
    send_word(0, rand_word(), 1);
    checks++;
    if (wa_q.size() != nbefore) begin
      errors++;
      $display("FAIL rx_in_run writes=%0d expected 0", wa_q.size() - nbefore);
    end
    fetch_reads(10);
  endtask

  task automatic test_reset_midload();
    int base;
    do_reset(1'b1, 1'b0);
    @(negedge clk);
    send_byte(0, 8'($urandom), 0);
    send_byte(0, 8'($urandom), 1);
    do_reset(1'b1, 1'b0);
    checks++;
    if (core_rst !== 1'b1) begin
      errors++;
      $display("FAIL midload_core_rst got=%b expected 1", core_rst);
    end
    @(negedge clk);
    base = wa_q.size();
    send_word(0, rand_word(), 2);
    send_word(0, ENDW, 1);
    check_writes(0, base, 1 << AW, "midload");
    fetch_reads(4);
  endtask

  task automatic test_overflow();
    int base;
    do_reset(1'b0, 1'b1);
    @(negedge clk);
    base = wa2_q.size();
    for (int i = 0; i < 4; i++) send_word(1, rand_word(), 2);
    repeat (2) @(negedge clk);
    checks++;
    if (prog_err2 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at_full err=%b expected 0", prog_err2);
    end
    send_word(1, rand_word(), 1);
    repeat (2) @(negedge clk);
    checks++;
    if (prog_err2 !== 1'b1 || prog_done2 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop err=%b done=%b expected err=1 done=0", prog_err2, prog_done2);
    end
    send_word(1, ENDW, 0);
    checks++;
    if (prog_done2 !== 1'b1 || prog_err2 !== 1'b1 || core_rst2 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_end done=%b err=%b core_rst=%b expected 1 1 0", prog_done2, prog_err2, core_rst2);
    end
    check_writes(1, base, 1 << AW2, "overflow");
  endtask

  initial begin
    test_reset();
    test_run_direct();
    test_program();
    test_reset_midload();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
